// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one live-sampling UART transmitter among NUM_REQ byte sources
// Define UART_TX_ARB_TAG_EN to precede every data frame with a tag frame carrying 0xA0 | requester id.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int CLKS_PER_BIT = 217,
  parameter  int GAP_CLKS     = 2,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [7:0]           o_TX_Byte,
  output logic                 o_TX_DV,
  output logic                 o_Busy,
  output logic [IDW-1:0]       o_Grant_Id
);

  localparam int FRAME_CLKS = 10 * (CLKS_PER_BIT + 1);
  localparam int WAIT_CLKS  = FRAME_CLKS + GAP_CLKS;
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CLKS - 1);
`ifdef UART_TX_ARB_TAG_EN
  localparam logic [15:0] WAIT_FULL = 16'(WAIT_CLKS);
`endif

  typedef enum logic [2:0] {
    S_HOLD,
    S_ARB,
    S_LAUNCH,
    S_WAIT
`ifdef UART_TX_ARB_TAG_EN
    , S_LAUNCH_TAG
    , S_WAIT_TAG
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      cnt;
  logic             cnt_run;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   nxt_ptr;
  logic [IDW-1:0]   scan;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             take;
  logic [7:0]       win_byte;
`ifdef UART_TX_ARB_TAG_EN
  logic [7:0]       data_q;
`endif

  function automatic logic [IDW-1:0] wrap_idx(input int s);
    return (s >= NUM_REQ) ? IDW'(s - NUM_REQ) : IDW'(s);
  endfunction

  // Search starts at rr_ptr so the requester after the last winner has top priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = wrap_idx(int'(rr_ptr) + i);
      if (!found && i_Req_Valid[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  assign win_byte = i_Req_Byte[{winner, 3'b000} +: 8];
  assign nxt_ptr  = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign take     = (state == S_ARB) && found && !i_Reset;
  assign o_Busy   = (state != S_ARB);

  always_comb begin
    state_nxt   = state;
    cnt_run     = 1'b0;
    o_Req_Ready = '0;
    o_TX_DV     = 1'b0;
    case (state)
      S_HOLD: begin
        if (cnt == WAIT_LAST) state_nxt = S_ARB;
        else                  cnt_run   = 1'b1;
      end
      S_ARB: begin
        if (found) begin
          o_Req_Ready[winner] = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
          state_nxt = S_LAUNCH_TAG;
`else
          state_nxt = S_LAUNCH;
`endif
        end
      end
      S_LAUNCH: begin
        o_TX_DV   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == WAIT_LAST) state_nxt = S_ARB;
        else                  cnt_run   = 1'b1;
      end
`ifdef UART_TX_ARB_TAG_EN
      S_LAUNCH_TAG: begin
        o_TX_DV   = 1'b1;
        state_nxt = S_WAIT_TAG;
      end
      // One extra cycle stands in for the ARB slot so tag->data spacing matches data->tag spacing.
      S_WAIT_TAG: begin
        if (cnt == WAIT_FULL) state_nxt = S_LAUNCH;
        else                  cnt_run   = 1'b1;
      end
`endif
      default: state_nxt = S_HOLD;
    endcase
    if (i_Reset) begin
      o_Req_Ready = '0;
      o_TX_DV     = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state      <= S_HOLD;
      cnt        <= '0;
      rr_ptr     <= '0;
      o_TX_Byte  <= '0;
      o_Grant_Id <= '0;
`ifdef UART_TX_ARB_TAG_EN
      data_q     <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_run ? cnt + 16'd1 : '0;
      if (take) begin
        o_Grant_Id <= winner;
        rr_ptr     <= nxt_ptr;
`ifdef UART_TX_ARB_TAG_EN
        o_TX_Byte  <= 8'hA0 | 8'(winner);
        data_q     <= win_byte;
`else
        o_TX_Byte  <= win_byte;
`endif
      end
`ifdef UART_TX_ARB_TAG_EN
      if (state == S_WAIT_TAG && state_nxt == S_LAUNCH) o_TX_Byte <= data_q;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - table-driven scoreboard bench for uart_tx_arbiter (NUM_REQ=4, CLKS_PER_BIT=4, GAP_CLKS=2)
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int CPB       = 4;
  localparam int GAP       = 2;
  localparam int WAIT_CLKS = 10 * (CPB + 1) + GAP;
  localparam int SPACING   = WAIT_CLKS + 2;
`ifdef UART_TX_ARB_TAG_EN
  localparam int FR = 2;
`else
  localparam int FR = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_byte  = '0;
  logic [3:0]  o_Req_Ready;
  logic [7:0]  o_TX_Byte;
  logic        o_TX_DV;
  logic        o_Busy;
  logic [1:0]  o_Grant_Id;

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .CLKS_PER_BIT (CPB),
    .GAP_CLKS     (GAP)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req_Valid (req_valid),
    .i_Req_Byte  (req_byte),
    .o_Req_Ready (o_Req_Ready),
    .o_TX_Byte   (o_TX_Byte),
    .o_TX_DV     (o_TX_DV),
    .o_Busy      (o_Busy),
    .o_Grant_Id  (o_Grant_Id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  // order holds grant ids one nibble each, first grant in the low nibble.
  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] bytes;
    logic [3:0]  drop;
    logic        oneshot;
    logic [3:0]  n;
    logic [19:0] order;
  } row_t;

  exp_t        sb[$];
  row_t        rows[6];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          last_dv = -1;
  int          hold_left = 0;
  int          grants = 0;
  int          cur_n = 0;
  logic        hold_err = 1'b0;
  logic [7:0]  hold_byte = '0;
  logic [19:0] cur_order = '0;
  logic [3:0]  cur_drop = '0;
  logic        cur_oneshot = 1'b0;
  logic [3:0]  s_ready = '0;
  logic        s_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon();
    int k;
    exp_t e;
    cyc++;
    s_ready = o_Req_Ready;
    s_busy  = o_Busy;
    if (hold_left > 0) begin
      if (o_TX_Byte != hold_byte) hold_err = 1'b1;
      hold_left--;
      if (hold_left == 0) check("byte_hold", int'(hold_err), 0);
    end
    if (o_Req_Ready != 4'b0000) begin
      k = 0;
      for (int i = 0; i < NREQ; i++) if (o_Req_Ready[i]) k = i;
      check("ready_onehot", int'($onehot(o_Req_Ready)), 1);
      check("ready_in_arb", int'(o_Busy), 0);
      check("ready_valid", int'(req_valid[k]), 1);
      if (grants < cur_n) check("grant_order", k, int'(cur_order[4*grants +: 4]));
      else                check("extra_grant", grants + 1, cur_n);
`ifdef UART_TX_ARB_TAG_EN
      e.id = k[1:0];
      e.b  = 8'hA0 | {6'd0, k[1:0]};
      sb.push_back(e);
`endif
      e.id = k[1:0];
      e.b  = 8'(req_byte >> (8 * k));
      sb.push_back(e);
      grants++;
    end
    if (o_TX_DV) begin
      if (sb.size() == 0) begin
        check("dv_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("dv_byte", int'(o_TX_Byte), int'(e.b));
        check("dv_grant_id", int'(o_Grant_Id), int'(e.id));
      end
      if (last_dv >= 0) check("dv_spacing", cyc - last_dv, SPACING);
      last_dv   = cyc;
      hold_left = WAIT_CLKS - 1;
      hold_byte = o_TX_Byte;
      hold_err  = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic upd_valid();
    if (cur_oneshot) req_valid = req_valid & ~s_ready;
    if (grants >= 1) req_valid = req_valid & ~cur_drop;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    hold_left = 0;
    last_dv   = -1;
    grants    = 0;
    sb.delete();
    step();
    check("reset_tx_byte", int'(o_TX_Byte), 0);
    check("reset_grant_id", int'(o_Grant_Id), 0);
    check("reset_busy", int'(o_Busy), 1);
    check("reset_dv", int'(o_TX_DV), 0);
    check("reset_ready", int'(o_Req_Ready), 0);
    step();
    rst = 1'b0;
  endtask

  task automatic hold_chk();
    int  nb = 0;
    bit  done = 1'b0;
    while (!done && nb < 200) begin
      step();
      if (s_busy) nb++;
      else        done = 1'b1;
    end
    check("hold_busy_cycles", nb, WAIT_CLKS);
  endtask

  task automatic run_window(input int w);
    for (int i = 1; i < w; i++) begin
      upd_valid();
      step();
    end
  endtask

  initial begin
    rows[0] = '{valid: 4'b0100, bytes: 32'h005A0000, drop: 4'b0000, oneshot: 1'b1, n: 4'd1, order: 20'h00002};
    rows[1] = '{valid: 4'b1111, bytes: 32'h13121110, drop: 4'b0000, oneshot: 1'b0, n: 4'd5, order: 20'h03210};
    rows[2] = '{valid: 4'b1011, bytes: 32'h3D002B1A, drop: 4'b0010, oneshot: 1'b0, n: 4'd4, order: 20'h03030};
    rows[3] = '{valid: 4'b0001, bytes: 32'h000000C3, drop: 4'b0000, oneshot: 1'b0, n: 4'd3, order: 20'h00000};
    rows[4] = '{valid: 4'b0110, bytes: 32'h00428100, drop: 4'b0000, oneshot: 1'b0, n: 4'd4, order: 20'h02121};
    rows[5] = '{valid: 4'b1000, bytes: 32'h7E000000, drop: 4'b0000, oneshot: 1'b0, n: 4'd2, order: 20'h00033};

    for (int r = 0; r < 6; r++) begin
      req_valid   = rows[r].valid;
      req_byte    = rows[r].bytes;
      cur_drop    = rows[r].drop;
      cur_oneshot = rows[r].oneshot;
      cur_n       = int'(rows[r].n);
      cur_order   = rows[r].order;
      do_reset();
      hold_chk();
      run_window((rows[r].oneshot ? cur_n + 1 : cur_n) * FR * SPACING);
      check("grant_count", grants, cur_n);
      check("sb_empty", sb.size(), 0);
    end

    // Reset twenty cycles into a frame, then the full hold must pass before any grant.
    req_valid   = 4'b1111;
    req_byte    = 32'h13121110;
    cur_drop    = '0;
    cur_oneshot = 1'b0;
    cur_n       = 1;
    cur_order   = '0;
    do_reset();
    hold_chk();
    step();
    check("midframe_dv_seen", last_dv, cyc);
    repeat (20) step();
    do_reset();
    hold_chk();
    run_window(FR * SPACING);
    check("post_reset_grant_count", grants, 1);
    check("post_reset_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte sources using round-robin arbitration.
- The transmitter has no busy output and samples its byte input live for the whole frame. This block therefore:
  - holds the granted byte stable on o_TX_Byte;
  - issues a one-cycle o_TX_DV pulse;
  - times the frame itself before granting again.
- Sits between the application byte producers and the UART transmitter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 217, clocks per UART bit; must match the transmitter's parameter.
- GAP_CLKS, 2, extra idle clocks after each frame before the next DV pulse (0..255).

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req_Valid  in  NUM_REQ  per-requester byte valid.
- i_Req_Byte  in  8*NUM_REQ  requester k byte at [8k+7:8k].
- o_Req_Ready  out  NUM_REQ  one-hot accept strobe.
- o_TX_Byte  out  8  byte to transmitter; held stable for the full frame.
- o_TX_DV  out  1  one-cycle start pulse to transmitter.
- o_Busy  out  1  high in every state except ARB.
- o_Grant_Id  out  clog2(NUM_REQ)  index of the last granted requester.

Behaviour:
Frame timing
- FRAME_CLKS = 10*(CLKS_PER_BIT+1).
- WAIT_CLKS = FRAME_CLKS + GAP_CLKS.
- Wait counter: 16 bits; counts 0..WAIT_CLKS-1; never wraps.

States
- HOLD: entered on reset.
  - Purpose: the transmitter is not reset and may still be mid-frame.
  - Counts WAIT_CLKS cycles, then goes to ARB.
- ARB:
  - Winner = first k with i_Req_Valid[k]=1, searching from rr_ptr upward, modulo NUM_REQ.
  - o_Req_Ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - Transfer happens on that clock edge: o_TX_Byte <= winner's byte, o_Grant_Id <= winner, rr_ptr <= (winner+1) mod NUM_REQ, state -> LAUNCH.
  - No valid: stay in ARB; ready all 0.
- LAUNCH: o_TX_DV=1 for exactly this cycle; counter cleared; -> WAIT.
- WAIT:
  - o_TX_Byte held unchanged.
  - When counter reaches WAIT_CLKS-1 -> ARB.
  - First DV-to-DV spacing between back-to-back bytes is WAIT_CLKS+2 cycles.

Handshake
- A requester holds valid and byte stable until it sees ready.
- Ready is never asserted outside ARB.
- At most one byte is accepted per frame.
- Dropping valid before grant is legal; that requester is then simply skipped.

Simultaneous requests and fairness
- All requesters valid: grants rotate 0,1,2,3,0,...
- A requester can win twice in a row only if no other requester is valid.

Reset
- Reset values: state=HOLD, counter=0, rr_ptr=0, o_TX_Byte=0x00, o_TX_DV=0, o_Req_Ready=0, o_Grant_Id=0.
- o_Busy=1 during HOLD.
- Reset mid-frame: the DV pulse is suppressed immediately and no new grant is issued until HOLD completes.
- i_Reset has priority over all other events.

Optional Feature:
UART_TX_ARB_TAG_EN
- Defined:
  - Each grant sends two frames: a tag frame, then the data frame.
  - Tag byte = 0xA0 | winner index.
  - States become ARB -> LAUNCH_TAG -> WAIT_TAG -> LAUNCH -> WAIT.
  - o_TX_Byte = tag byte during LAUNCH_TAG/WAIT_TAG, then the captured data byte.
  - The data byte is captured at grant time in an internal register.
  - Ready timing is unchanged: a single strobe in ARB.
- Undefined: one frame per grant exactly as described above; no tag logic is synthesised.

Test Plan:
- Reset, CLKS_PER_BIT=4, GAP_CLKS=2: o_Busy=1 for 52 cycles after reset release. No ready or DV during that window, even with all valid high. Then ARB.
- Only req2 valid, byte 0x5A:
  - ready[2] pulses once;
  - next cycle o_TX_DV=1 with o_TX_Byte=0x5A;
  - o_TX_Byte stays 0x5A for 52 cycles;
  - o_Grant_Id=2.
- All four valid continuously, bytes 0x10..0x13: DV pulses carry 0x10,0x11,0x12,0x13,0x10, each spaced 54 cycles apart. Ready is one-hot every time.
- Req1 drops valid before its turn while req0 and req3 stay valid: grant order is 0,3,0,3. No ready is ever given to 1.
- Assert i_Reset in the WAIT cycle 20 after DV: outputs return to reset values next edge. No DV for 52 cycles after release.
- With UART_TX_ARB_TAG_EN, req3 sends 0x7E:
  - DV with 0xA3;
  - 54 cycles later DV with 0x7E;
  - a single ready[3] strobe.
